// File: rtl/io_uart_pkg.sv
// io_uart_tx shared definitions: register map, bit positions,
// transmit FSM states and the power-on baud divisor.
package io_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  localparam int CT_EN    = 0;
  localparam int CT_FLUSH = 1;
  localparam int CT_CLR   = 2;
  localparam int CT_ODD   = 3;

  // 115200 baud at 50 MHz: bit period is divisor+1 clocks
  localparam logic [15:0] BAUD_RESET_DFLT = 16'd433;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/io_uart_fifo.sv
// io_uart_tx transmit queue: synchronous FIFO with
// one-cycle flush; push while full or during flush is ignored.
module io_uart_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: I/O-bus UART transmitter, 8N1 with FIFO.
// Define IO_UART_TX_PARITY_EN to insert a parity bit (8E1/8O1).
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = BAUD_RESET_DFLT
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic        CS,
  input  logic [3:0]  IOA,
  input  logic [31:0] IOD,
  input  logic        IOE,
  output logic [31:0] IOQ,
  output logic        TXD,
  output logic        IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  addr;
  logic        wr;
  logic        push;
  logic        flush;
  logic        clr_ovf;
  logic        pop;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic [CW-1:0] count;

  logic [15:0] baud_q;
  logic        en_q;
  logic        odd_q;
  logic        ovf_q;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        txd;
  logic        tick;
  logic        unused;

  assign addr    = IOA[1:0];
  assign wr      = CS & IOE;
  assign push    = wr & (addr == REG_DATA);
  assign flush   = wr & (addr == REG_CTRL) & IOD[CT_FLUSH];
  assign clr_ovf = wr & (addr == REG_CTRL) & IOD[CT_CLR];
  assign unused  = ^{IOA[3:2], IOD[31:16]};

  io_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (N_RST),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (IOD[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // software-visible registers and sticky overflow
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      baud_q <= BAUD_RESET;
      en_q   <= 1'b0;
      odd_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr && addr == REG_BAUD) baud_q <= IOD[15:0];
      if (wr && addr == REG_CTRL) begin
        en_q  <= IOD[CT_EN];
        odd_q <= IOD[CT_ODD];
      end
      if (clr_ovf)                       ovf_q <= 1'b0;
      else if (push && full && !flush)   ovf_q <= 1'b1;
    end
  end

  // side-effect-free read mux
  always_comb begin
    IOQ = '0;
    case (addr)
      REG_STATUS: begin
        IOQ[ST_BUSY]  = (state_q != S_IDLE);
        IOQ[ST_FULL]  = full;
        IOQ[ST_EMPTY] = empty;
        IOQ[ST_OVF]   = ovf_q;
        IOQ[8:4]      = 5'(count);
      end
      REG_BAUD: IOQ[15:0] = baud_q;
      REG_CTRL: begin
        IOQ[CT_EN]  = en_q;
        IOQ[CT_ODD] = odd_q;
      end
      default: IOQ = '0;
    endcase
  end

  // transmit FSM and bit-timing registers
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign tick = (cnt_q == '0);

  // next state, baud reload at each bit boundary, line level
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? baud_q : cnt_q - 16'd1;
    idx_d   = idx_q;
    data_d  = data_q;
    pop     = 1'b0;
    txd     = 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (en_q && !empty) begin
          pop     = 1'b1;
          data_d  = head;
          cnt_d   = baud_q;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        txd = data_q[idx_q];
        if (tick) begin
          if (idx_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: begin
        txd = ^data_q ^ odd_q;
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign TXD = txd;
  assign IRQ = empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: randomized self-checking bench for io_uart_tx.
// Frames are predicted as bit lists expanded by bit period.
module tb_io_uart_tx;

  logic        CLK;
  logic        N_RST;
  logic        CS;
  logic [3:0]  IOA;
  logic [31:0] IOD;
  logic        IOE;
  logic [31:0] IOQ;
  logic        TXD;
  logic        IRQ;

  int total;
  int bad;
  bit odd_mode;

  io_uart_tx #(
    .FIFO_DEPTH (8),
    .BAUD_RESET (16'd433)
  ) dut (
    .CLK   (CLK),
    .N_RST (N_RST),
    .CS    (CS),
    .IOA   (IOA),
    .IOD   (IOD),
    .IOE   (IOE),
    .IOQ   (IOQ),
    .TXD   (TXD),
    .IRQ   (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge CLK);
    CS  = 1'b1;
    IOE = 1'b1;
    IOA = {2'b00, a};
    IOD = {16'h0, d};
    @(posedge CLK);
    #1;
    CS  = 1'b0;
    IOE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    @(negedge CLK);
    IOA = {2'b00, a};
    #1;
    q = IOQ;
  endtask

  // Expected waveform: start, 8 data LSB first, [parity], stop;
  // bits with index >= chg_bit use period b1+1, earlier ones b0+1.
  task automatic check_frame(input logic [7:0] d, input int b0,
                             input int b1, input int chg_bit,
                             input bit btb, input int inj_at,
                             input logic [1:0] ia,
                             input logic [15:0] id,
                             input string name);
    logic bits[$];
    logic expq[$];
    int   errs;
    int   first;
    logic fgot;
    logic fexp;
    bit   found;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef IO_UART_TX_PARITY_EN
    bits.push_back((^d) ^ odd_mode);
`endif
    bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++) begin
      int dur;
      dur = (j < chg_bit) ? b0 : b1;
      for (int k = 0; k <= dur; k++) expq.push_back(bits[j]);
    end
    found = 1'b0;
    if (btb) begin
      @(negedge CLK);
      total++;
      if (TXD !== 1'b1) begin
        bad++;
        $display("FAIL %s gap: txd=%b want 1", name, TXD);
      end
      @(negedge CLK);
      found = (TXD === 1'b0);
    end else begin
      for (int t = 0; t < 4000 && !found; t++) begin
        @(negedge CLK);
        if (TXD === 1'b0) found = 1'b1;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s start: txd=%b want 0", name, TXD);
      return;
    end
    errs  = 0;
    first = -1;
    fgot  = 1'b0;
    fexp  = 1'b0;
    for (int i = 0; i < expq.size(); i++) begin
      if (i > 0) @(negedge CLK);
      if (TXD !== expq[i] || IRQ !== 1'b0 ||
          (IOA == 4'd1 && IOQ[0] !== 1'b1)) begin
        errs++;
        if (first < 0) begin
          first = i;
          fgot  = TXD;
          fexp  = expq[i];
        end
      end
      if (i == inj_at) begin
        CS  = 1'b1;
        IOE = 1'b1;
        IOA = {2'b00, ia};
        IOD = {16'h0, id};
      end
      if (i == inj_at + 1) begin
        CS  = 1'b0;
        IOE = 1'b0;
      end
    end
    if (errs != 0) begin
      bad++;
      $display("FAIL %s frame %02h: sample %0d txd=%b want %b (%0d bad)",
               name, d, first, fgot, fexp, errs);
    end
  endtask

  task automatic test_reset;
    logic [31:0] q;
    total++;
    if (TXD !== 1'b1 || IRQ !== 1'b1) begin
      bad++;
      $display("FAIL reset_pins: txd=%b irq=%b want 1 1", TXD, IRQ);
    end
    rd(2'd1, q);
    total++;
    if (q !== 32'h4) begin
      bad++;
      $display("FAIL reset_status: got %h want 00000004", q);
    end
    rd(2'd2, q);
    total++;
    if (q !== 32'd433) begin
      bad++;
      $display("FAIL reset_baud: got %0d want 433", q);
    end
    rd(2'd3, q);
    total++;
    if (q !== 32'h0) begin
      bad++;
      $display("FAIL reset_ctrl: got %h want 0", q);
    end
    rd(2'd0, q);
    total++;
    if (q !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", q);
    end
  endtask

  task automatic test_frame_55;
    logic [31:0] q;
    wr(2'd2, 16'd3);
    wr(2'd3, 16'h1);
    wr(2'd0, 16'h55);
    rd(2'd1, q);
    total++;
    if (q !== 32'h10) begin
      bad++;
      $display("FAIL queued_status: got %h want 00000010", q);
    end
    check_frame(8'h55, 3, 3, 99, 1'b0, -1, 2'd0, 16'h0, "frame55");
    @(negedge CLK);
    total++;
    if (IRQ !== 1'b1 || TXD !== 1'b1) begin
      bad++;
      $display("FAIL irq_after_frame: irq=%b txd=%b want 1 1", IRQ, TXD);
    end
  endtask

  task automatic test_random_frames;
    for (int r = 0; r < 3; r++) begin
      logic [7:0] q[$];
      int b;
      int n;
      b = int'($urandom_range(0, 4));
      n = int'($urandom_range(2, 6));
      wr(2'd3, 16'h0);
      wr(2'd2, 16'(b));
      for (int i = 0; i < n; i++) begin
        logic [7:0] d;
        d = 8'($urandom);
        q.push_back(d);
        wr(2'd0, {8'h0, d});
      end
      wr(2'd3, 16'h1);
      for (int i = 0; i < n; i++)
        check_frame(q[i], b, b, 99, i > 0, -1, 2'd0, 16'h0, "random");
      @(negedge CLK);
      total++;
      if (IRQ !== 1'b1) begin
        bad++;
        $display("FAIL random_irq: irq=%b want 1", IRQ);
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0]  q[$];
    logic [31:0] s;
    int b;
    b = int'($urandom_range(0, 2));
    wr(2'd3, 16'h0);
    wr(2'd2, 16'(b));
    for (int i = 0; i < 9; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      q.push_back(d);
      wr(2'd0, {8'h0, d});
    end
    rd(2'd1, s);
    total++;
    if (s !== 32'h8A) begin
      bad++;
      $display("FAIL ovf_status: got %h want 0000008a", s);
    end
    wr(2'd3, 16'h4);
    rd(2'd1, s);
    total++;
    if (s !== 32'h82) begin
      bad++;
      $display("FAIL ovf_clear: got %h want 00000082", s);
    end
    wr(2'd3, 16'h1);
    for (int i = 0; i < 8; i++)
      check_frame(q[i], b, b, 99, i > 0, -1, 2'd0, 16'h0, "drain8");
    @(negedge CLK);
    total++;
    if (IRQ !== 1'b1 || TXD !== 1'b1) begin
      bad++;
      $display("FAIL drain_end: irq=%b txd=%b want 1 1", IRQ, TXD);
    end
  endtask

  task automatic test_baud_change;
    logic [7:0]  d;
    logic [31:0] s;
    d = 8'($urandom);
    wr(2'd3, 16'h0);
    wr(2'd2, 16'd3);
    wr(2'd0, {8'h0, d});
    wr(2'd3, 16'h1);
    check_frame(d, 3, 7, 4, 1'b0, 13, 2'd2, 16'd7, "baud_change");
    rd(2'd2, s);
    total++;
    if (s !== 32'd7) begin
      bad++;
      $display("FAIL baud_readback: got %0d want 7", s);
    end
  endtask

  task automatic test_flush;
    logic [7:0]  q[$];
    logic [31:0] s;
    bit          quiet;
    wr(2'd3, 16'h0);
    wr(2'd2, 16'd2);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      q.push_back(d);
      wr(2'd0, {8'h0, d});
    end
    wr(2'd3, 16'h1);
    check_frame(q[0], 2, 2, 99, 1'b0, 5, 2'd3, 16'h3, "flush_frame");
    @(negedge CLK);
    total++;
    if (IRQ !== 1'b1) begin
      bad++;
      $display("FAIL flush_irq: irq=%b want 1", IRQ);
    end
    rd(2'd1, s);
    total++;
    if (s !== 32'h4) begin
      bad++;
      $display("FAIL flush_status: got %h want 00000004", s);
    end
    rd(2'd3, s);
    total++;
    if (s !== 32'h1) begin
      bad++;
      $display("FAIL flush_ctrl: got %h want 00000001", s);
    end
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (TXD !== 1'b1) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL flush_quiet: txd went 0 want idle 1");
    end
  endtask

  task automatic test_reset_midframe;
    bit found;
    bit quiet;
    wr(2'd2, 16'd5);
    wr(2'd0, 16'($urandom_range(0, 255)));
    wr(2'd0, 16'($urandom_range(0, 255)));
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge CLK);
      if (TXD === 1'b0) found = 1'b1;
    end
    repeat (20) @(negedge CLK);
    N_RST = 1'b0;
    #1;
    total++;
    if (!found || TXD !== 1'b1 || IRQ !== 1'b1) begin
      bad++;
      $display("FAIL rst_pins: started=%b txd=%b irq=%b want 1 1 1",
               found, TXD, IRQ);
    end
    IOA = 4'd1;
    #1;
    total++;
    if (IOQ !== 32'h4) begin
      bad++;
      $display("FAIL rst_status: got %h want 00000004", IOQ);
    end
    IOA = 4'd2;
    #1;
    total++;
    if (IOQ !== 32'd433) begin
      bad++;
      $display("FAIL rst_baud: got %0d want 433", IOQ);
    end
    @(negedge CLK);
    N_RST = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (TXD !== 1'b1) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL rst_quiet: txd went 0 want idle 1");
    end
  endtask

  task automatic test_odd_ctrl;
    logic [31:0] s;
    wr(2'd2, 16'd1);
    wr(2'd3, 16'h9);
    odd_mode = 1'b1;
    rd(2'd3, s);
    total++;
    if (s !== 32'h9) begin
      bad++;
      $display("FAIL ctrl_odd_readback: got %h want 00000009", s);
    end
    wr(2'd0, 16'h07);
    check_frame(8'h07, 1, 1, 99, 1'b0, -1, 2'd0, 16'h0, "odd07");
    wr(2'd3, 16'h0);
    odd_mode = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    odd_mode = 1'b0;
    N_RST    = 1'b0;
    CS       = 1'b0;
    IOE      = 1'b0;
    IOA      = 4'd0;
    IOD      = 32'h0;
    repeat (2) @(negedge CLK);
    N_RST = 1'b1;
    test_reset;
    test_frame_55;
    test_random_frames;
    test_overflow;
    test_baud_change;
    test_odd_ctrl;
    test_flush;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
